// File: rtl/video_timing_gen.sv
// Video timing generator: PLL-lock gated raster counters with registered sync/DE outputs.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SETTLE   = 1024
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       running,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned SW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SBEG_L = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SEND_L = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST_L = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SBEG_L = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SEND_L = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST_L = 10'(V_TOTAL - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          lock_s;
  logic [SW-1:0] settle_q, settle_d;
  logic [9:0]    hc_q, hc_d;
  logic [9:0]    vc_q, vc_d;

  logic          run;
  logic          running_d, hsync_d, vsync_d, de_d, frame_start_d;
  logic [9:0]    x_d, y_d;

  assign lock_s = sync_q[1];

  // Next state, settle counter and raster counters; counters stay at zero outside RUN
  // so the first RUN cycle always starts a fresh frame at (0,0).
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    hc_d     = '0;
    vc_d     = '0;
    unique case (state_q)
      S_WAIT_LOCK: begin
        settle_d = '0;
        if (lock_s) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = S_RUN;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (hc_q == H_LAST_L) begin
          hc_d = '0;
          vc_d = (vc_q == V_LAST_L) ? '0 : vc_q + 1'b1;
        end else begin
          hc_d = hc_q + 1'b1;
          vc_d = vc_q;
        end
      end
      default: state_d = S_WAIT_LOCK;
    endcase
  end

  // Output decode from the current raster position; registered below for one-cycle latency.
  always_comb begin
    run           = (state_q == S_RUN);
    running_d     = run;
    de_d          = run && (hc_q < H_ACT_L) && (vc_q < V_ACT_L);
    hsync_d       = !(run && (hc_q >= H_SBEG_L) && (hc_q < H_SEND_L));
    vsync_d       = !(run && (vc_q >= V_SBEG_L) && (vc_q < V_SEND_L));
    x_d           = run ? hc_q : '0;
    y_d           = run ? vc_q : '0;
    frame_start_d = run && (hc_q == '0) && (vc_q == '0);
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      sync_q      <= '0;
      state_q     <= S_WAIT_LOCK;
      settle_q    <= '0;
      hc_q        <= '0;
      vc_q        <= '0;
      running     <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], pll_locked};
      state_q     <= state_d;
      settle_q    <= settle_d;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      running     <= running_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      de          <= de_d;
      x           <= x_d;
      y           <= y_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int ST = 20;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int STARTUP = 2 + 1 + ST + 1;
  localparam logic [24:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'd0};

  logic       clki = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       running, hsync, vsync, de, frame_start;
  logic [9:0] x, y;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SETTLE(ST)
  ) dut (
    .clki(clki), .rst(rst), .pll_locked(pll_locked),
    .running(running), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .frame_start(frame_start)
  );

  always #20 clki = ~clki;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [24:0] obs = '0;
  logic [24:0] sb_q[$];

  // reference model: lock pipeline, mode 0=wait 1=settle 2=run, linear pixel index
  int   m_mode = 0;
  int   m_cnt = 0;
  int   m_p = 0;
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [24:0] model_out();
    int hc, vc;
    logic h, v, d, f;
    if (m_mode != 2) return RST_VEC;
    hc = m_p % HT;
    vc = m_p / HT;
    d  = (hc < HA) && (vc < VA);
    h  = !((hc >= HA + HF) && (hc < HA + HF + HS));
    v  = !((vc >= VA + VF) && (vc < VA + VF + VS));
    f  = (m_p == 0);
    return {1'b1, h, v, d, f, 10'(hc), 10'(vc)};
  endfunction

  task automatic model_edge(input logic r, input logic l);
    logic lk;
    if (r) begin
      sb_q.push_back(RST_VEC);
      m_mode = 0; m_cnt = 0; m_p = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      sb_q.push_back(model_out());
      lk = m_s2;
      case (m_mode)
        0: if (lk) begin m_mode = 1; m_cnt = 0; end
        1: begin
          if (!lk) m_mode = 0;
          else if (m_cnt == ST - 1) begin m_mode = 2; m_p = 0; end
          else m_cnt++;
        end
        default: begin
          if (!lk) begin m_mode = 0; m_p = 0; end
          else m_p = (m_p + 1) % FRAME;
        end
      endcase
      m_s2 = m_s1;
      m_s1 = l;
    end
  endtask

  task automatic cycle(input logic r, input logic l);
    logic [24:0] e;
    rst = r;
    pll_locked = l;
    model_edge(r, l);
    @(posedge clki);
    #1;
    cyc++;
    obs = {running, hsync, vsync, de, frame_start, x, y};
    e = sb_q.pop_front();
    chk("out", obs, e);
    @(negedge clki);
  endtask

  task automatic wait_run(input int budget, output int n);
    n = 0;
    while (!obs[24] && n < budget) begin
      cycle(1'b0, 1'b1);
      n++;
    end
  endtask

  initial begin
    int n, de_n, hs_n, vs_n, fs_n, last_fs, per, hs_x, vy_min, vy_max;
    logic prev_hs;

    repeat (3) cycle(1'b1, 1'b0);
    chk("rst_vals", obs, RST_VEC);

    // startup
    wait_run(200, n);
    chk("startup_lat", n, STARTUP);
    chk("startup_fs_xy", obs[20:0], {1'b1, 20'd0});

    // two full frames
    de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0; per = 0;
    last_fs = cyc; hs_x = 0; vy_min = 1023; vy_max = 0; prev_hs = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(1'b0, 1'b1);
      de_n += int'(obs[21]);
      if (!obs[23]) hs_n++;
      if (prev_hs && !obs[23]) hs_x = int'(obs[19:10]);
      prev_hs = obs[23];
      if (!obs[22]) begin
        vs_n++;
        if (int'(obs[9:0]) < vy_min) vy_min = int'(obs[9:0]);
        if (int'(obs[9:0]) > vy_max) vy_max = int'(obs[9:0]);
      end
      if (obs[20]) begin
        fs_n++;
        per = cyc - last_fs;
        last_fs = cyc;
      end
    end
    chk("fs_count", fs_n, 2);
    chk("fs_period", per, FRAME);
    chk("de_count", de_n, 2 * HA * VA);
    chk("hs_low_count", hs_n, 2 * HS * VT);
    chk("hs_start_x", hs_x, HA + HF);
    chk("vs_low_count", vs_n, 2 * VS * HT);
    chk("vs_y_min", vy_min, VA + VF);
    chk("vs_y_max", vy_max, VA + VF + VS - 1);

    // lock loss in RUN at (5,3)
    n = 0;
    while (!(obs[19:10] == 10'd5 && obs[9:0] == 10'd3) && n < FRAME + 5) begin
      cycle(1'b0, 1'b1);
      n++;
    end
    chk("loss_pos", obs[19:0], {10'd5, 10'd3});
    cycle(1'b0, 1'b0);
    n = 0;
    while (obs[24] && n < 10) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    chk("loss_lat", n, 3);
    chk("loss_blank", obs[23:21], 3'b110);
    repeat (4) cycle(1'b0, 1'b0);
    wait_run(200, n);
    chk("relock_lat", n, STARTUP);
    chk("relock_fs_xy", obs[20:0], {1'b1, 20'd0});

    // reset pulse in RUN
    repeat (37) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    chk("rst_in_run", obs, RST_VEC);
    wait_run(200, n);
    chk("rst_restart_lat", n, STARTUP);

    // settle abort at count 10
    cycle(1'b1, 1'b1);
    repeat (13) cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0);
    chk("abort_norun", obs[24], 1'b0);
    wait_run(200, n);
    chk("abort_lat", n, STARTUP);

    // one-cycle lock glitch in RUN
    repeat (50) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    n = 0;
    while (obs[24] && n < 10) begin
      cycle(1'b0, 1'b1);
      n++;
    end
    chk("glitch_lat", n, 3);
    wait_run(200, n);
    chk("glitch_restart", obs[20:0], {1'b1, 20'd0});
    repeat (10) cycle(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
